// File: rtl/demux_1_4_buf_if.sv
// Handshake bundle for demux_1_4_buf: one producer (enb/a/sel) and four buffered consumer slots (y0..y3).
interface demux_1_4_buf_if #(
    parameter int WIDTH = 32
);
    logic               enb;
    logic [0:WIDTH-1]   a;
    logic [0:1]         sel;
    logic               a_valid;
    logic               a_ready;
    logic [0:WIDTH-1]   y0;
    logic [0:WIDTH-1]   y1;
    logic [0:WIDTH-1]   y2;
    logic [0:WIDTH-1]   y3;
    logic [0:3]         y_valid;
    logic [0:3]         y_ready;

    modport master (
        output enb, a, sel, a_valid, y_ready,
        input  a_ready, y0, y1, y2, y3, y_valid
    );

    modport slave (
        input  enb, a, sel, a_valid, y_ready,
        output a_ready, y0, y1, y2, y3, y_valid
    );
endinterface

// File: rtl/demux_1_4_buf.sv
// Registered 1-to-4 demultiplexer with a one-entry holding buffer per output slot.
// Optional build macro DEMUX_1_4_BUF_XCNT_EN adds a wrapping input-transfer counter (xcnt/xcnt_clr).
module demux_1_4_buf #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
`ifdef DEMUX_1_4_BUF_XCNT_EN
    input  logic            xcnt_clr,
    output logic [0:15]     xcnt,
`endif
    demux_1_4_buf_if.slave  bus
);
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    slot_state_e        state_r     [4];
    slot_state_e        state_nxt_s [4];
    logic [0:WIDTH-1]   data_r      [4];
    logic [1:0]         sel_idx_s;
    logic               a_ready_s;
    logic               in_xfer_s;
    logic [3:0]         load_s;
    logic [3:0]         out_xfer_s;
    logic [0:3]         y_valid_s;

    // Output/handshake decode; a FULL slot may be refilled only while its consumer drains it.
    always_comb begin
        sel_idx_s  = bus.sel;
        a_ready_s  = 1'b0;
        in_xfer_s  = 1'b0;
        load_s     = 4'b0000;
        out_xfer_s = 4'b0000;
        y_valid_s  = 4'b0000;
        if (rst && bus.enb) begin
            a_ready_s = (state_r[sel_idx_s] == SLOT_EMPTY) || bus.y_ready[sel_idx_s];
        end else begin
            a_ready_s = 1'b0;
        end
        in_xfer_s = bus.a_valid && a_ready_s;
        for (int i = 0; i < 4; i++) begin
            load_s[i]     = in_xfer_s && (sel_idx_s == 2'(i));
            out_xfer_s[i] = (state_r[i] == SLOT_FULL) && bus.y_ready[i];
            y_valid_s[i]  = (state_r[i] == SLOT_FULL);
        end
    end

    // Next-state logic for the four independent slot FSMs.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_nxt_s[i] = state_r[i];
            case (state_r[i])
                SLOT_EMPTY: begin
                    if (load_s[i]) begin
                        state_nxt_s[i] = SLOT_FULL;
                    end else begin
                        state_nxt_s[i] = SLOT_EMPTY;
                    end
                end
                SLOT_FULL: begin
                    if (load_s[i]) begin
                        state_nxt_s[i] = SLOT_FULL;
                    end else if (out_xfer_s[i]) begin
                        state_nxt_s[i] = SLOT_EMPTY;
                    end else begin
                        state_nxt_s[i] = SLOT_FULL;
                    end
                end
                default: begin
                    state_nxt_s[i] = SLOT_EMPTY;
                end
            endcase
        end
    end

    // Slot state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                state_r[i] <= SLOT_EMPTY;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_r[i] <= state_nxt_s[i];
            end
        end
    end

    // Slot data registers; an EMPTY slot keeps its last word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                data_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load_s[i]) begin
                    data_r[i] <= bus.a;
                end else begin
                    data_r[i] <= data_r[i];
                end
            end
        end
    end

`ifdef DEMUX_1_4_BUF_XCNT_EN
    logic [15:0] xcnt_r;

    // Input-transfer counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xcnt_r <= 16'h0000;
        end else if (xcnt_clr) begin
            xcnt_r <= 16'h0000;
        end else if (in_xfer_s) begin
            xcnt_r <= xcnt_r + 16'h0001;
        end else begin
            xcnt_r <= xcnt_r;
        end
    end

    assign xcnt = xcnt_r;
`endif

    assign bus.a_ready = a_ready_s;
    assign bus.y_valid = y_valid_s;
    assign bus.y0      = data_r[0];
    assign bus.y1      = data_r[1];
    assign bus.y2      = data_r[2];
    assign bus.y3      = data_r[3];
endmodule

// File: tb/tb_demux_1_4_buf.sv
// Scoreboard bench for demux_1_4_buf: per-slot expected-word queues filled on input transfers, drained by a monitor.
`timescale 1ns/1ps
module tb_demux_1_4_buf;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    demux_1_4_buf_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX_1_4_BUF_XCNT_EN
    logic        xcnt_clr = 1'b0;
    logic [0:15] xcnt;
    logic [15:0] exp_cnt  = 16'h0000;
`endif

    demux_1_4_buf #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef DEMUX_1_4_BUF_XCNT_EN
        .xcnt_clr (xcnt_clr),
        .xcnt     (xcnt),
`endif
        .bus      (bus)
    );

    logic [31:0] exp_q [4][$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] y_of(input int i);
        case (i)
            0:       return bus.y0;
            1:       return bus.y1;
            2:       return bus.y2;
            default: return bus.y3;
        endcase
    endfunction

    // Monitor: whenever a slot presents a word, compare it with the oldest expected word; pop on handshake.
    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("y_valid[%0d]", i), 32'(bus.y_valid[i]), 32'(exp_q[i].size() != 0));
                    if (bus.y_valid[i] && exp_q[i].size() != 0) begin
                        chk($sformatf("y%0d data", i), y_of(i), exp_q[i][0]);
                        if (bus.y_ready[i]) begin
                            void'(exp_q[i].pop_front());
                        end
                    end
                end
            end
        end
    end

    // One clock of stimulus: drive at posedge+1, check acceptance at negedge, record transfer after the edge.
    task automatic step(input logic en, input logic av, input logic [31:0] d, input logic [1:0] s,
                        input logic [0:3] yr, output logic acc);
        logic exp_rdy;
        bus.enb     = en;
        bus.a_valid = av;
        bus.a       = d;
        bus.sel     = s;
        bus.y_ready = yr;
        @(negedge clk);
        exp_rdy = rst && en && ((exp_q[s].size() == 0) || yr[s]);
        chk("a_ready", 32'(bus.a_ready), 32'(exp_rdy));
`ifdef DEMUX_1_4_BUF_XCNT_EN
        chk("xcnt", 32'(xcnt), 32'(exp_cnt));
`endif
        acc = av && exp_rdy;
        @(posedge clk);
        #1;
        if (acc) begin
            exp_q[s].push_back(d);
        end
`ifdef DEMUX_1_4_BUF_XCNT_EN
        if (xcnt_clr) begin
            exp_cnt = 16'h0000;
        end else if (acc) begin
            exp_cnt = exp_cnt + 16'h0001;
        end
`endif
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " y_valid"}, 32'(bus.y_valid), 32'h0);
        chk({tag, " y0"}, bus.y0, 32'h0);
        chk({tag, " y1"}, bus.y1, 32'h0);
        chk({tag, " y2"}, bus.y2, 32'h0);
        chk({tag, " y3"}, bus.y3, 32'h0);
        chk({tag, " a_ready"}, 32'(bus.a_ready), 32'h0);
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic        acc;
        logic        rv;
        logic        hold;
        logic [31:0] rd;
        logic [1:0]  rs;

        bus.enb = 1'b1; bus.a_valid = 1'b0; bus.a = '0; bus.sel = 2'd0; bus.y_ready = 4'b0000;
        #1;
        chk_reset_state("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Steering with all consumers ready.
        step(1'b1, 1'b1, 32'h010101, 2'd0, 4'b1111, acc);
        step(1'b1, 1'b1, 32'h020202, 2'd1, 4'b1111, acc);
        step(1'b1, 1'b1, 32'h030303, 2'd2, 4'b1111, acc);
        step(1'b1, 1'b1, 32'h040404, 2'd3, 4'b1111, acc);
        step(1'b1, 1'b0, 32'h0,      2'd0, 4'b1111, acc);

        // Backpressure on slot 1; slot 2 still accepts; release lets the stalled word in.
        step(1'b1, 1'b1, 32'h020202, 2'd1, 4'b1011, acc);
        step(1'b1, 1'b1, 32'h030303, 2'd2, 4'b1011, acc);
        step(1'b1, 1'b1, 32'h0A0A0A, 2'd1, 4'b1011, acc);
        step(1'b1, 1'b1, 32'h0A0A0A, 2'd1, 4'b1011, acc);
        step(1'b1, 1'b1, 32'h0A0A0A, 2'd1, 4'b1111, acc);
        chk("backpressure release", 32'(acc), 32'h1);
        step(1'b1, 1'b0, 32'h0,      2'd0, 4'b1111, acc);

        // Simultaneous drain and refill of slot 0.
        step(1'b1, 1'b1, 32'h010101, 2'd0, 4'b0111, acc);
        step(1'b1, 1'b1, 32'h050505, 2'd0, 4'b1111, acc);
        chk("refill accepted", 32'(acc), 32'h1);
        step(1'b1, 1'b0, 32'h0,      2'd0, 4'b0111, acc);
        step(1'b1, 1'b0, 32'h0,      2'd0, 4'b1111, acc);

        // Enable low: nothing loads while a held slot still drains.
        step(1'b1, 1'b1, 32'h060606, 2'd3, 4'b1110, acc);
        step(1'b0, 1'b1, 32'h070707, 2'd0, 4'b1110, acc);
        step(1'b0, 1'b1, 32'h070707, 2'd0, 4'b1111, acc);
        step(1'b1, 1'b1, 32'h070707, 2'd0, 4'b1111, acc);
        step(1'b1, 1'b0, 32'h0,      2'd0, 4'b1111, acc);

        // Reset mid-transfer with slot 2 FULL.
        step(1'b1, 1'b1, 32'h080808, 2'd2, 4'b1101, acc);
        bus.a_valid = 1'b1; bus.a = 32'h090909; bus.sel = 2'd0;
        #2;
        rst = 1'b0;
        #1;
        chk_reset_state("mid reset");
        for (int i = 0; i < 4; i++) exp_q[i].delete();
`ifdef DEMUX_1_4_BUF_XCNT_EN
        exp_cnt = 16'h0000;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("held reset");
        rst = 1'b1;
        step(1'b1, 1'b0, 32'h0, 2'd0, 4'b0000, acc);
        chk("a_ready after release", 32'(bus.a_ready), 32'h1);

`ifdef DEMUX_1_4_BUF_XCNT_EN
        xcnt_clr = 1'b1;
        step(1'b1, 1'b1, 32'h0B0B0B, 2'd1, 4'b1111, acc);
        xcnt_clr = 1'b0;
        chk("xcnt clr wins", 32'(xcnt), 32'h0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, $urandom, 2'(k), 4'b1111, acc);
        chk("xcnt three", 32'(xcnt), 32'h3);
        for (int k = 0; k < 65532; k++) step(1'b1, 1'b1, $urandom, 2'($urandom_range(0, 3)), 4'b1111, acc);
        chk("xcnt max", 32'(xcnt), 32'hFFFF);
        step(1'b1, 1'b1, 32'h0C0C0C, 2'd2, 4'b1111, acc);
        chk("xcnt wrap", 32'(xcnt), 32'h0);
`endif

        // Randomized traffic; the producer holds its word until accepted.
        hold = 1'b0; rv = 1'b0; rd = '0; rs = 2'd0;
        for (int c = 0; c < 3000; c++) begin
            if (!hold) begin
                rv = ($urandom_range(0, 3) != 0);
                rd = $urandom;
                rs = 2'($urandom_range(0, 3));
            end
            step(($urandom_range(0, 7) != 0), rv, rd, rs, 4'($urandom), acc);
            hold = rv && !acc;
        end
        step(1'b1, 1'b0, 32'h0, 2'd0, 4'b1111, acc);
        step(1'b1, 1'b0, 32'h0, 2'd0, 4'b1111, acc);
        for (int i = 0; i < 4; i++) chk($sformatf("drained slot %0d", i), 32'(exp_q[i].size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
